// File: rtl/vdu_tty.sv
// Console writer that masters the VDU slave bus: decodes a byte stream into
// character/attribute writes, scrolls and clears text memory, then updates the CRTC cursor.
module vdu_tty #(
  parameter logic [19:0] BASE = 20'hB8000,
  parameter logic [7:0]  ATTR = 8'h07,
  parameter int          COLS = 80,
  parameter int          ROWS = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [19:0] a,
  inout  wire  [7:0]  d,
  output logic        memr,
  output logic        memw,
  output logic        iow,
  output logic [6:0]  cur_col,
  output logic [4:0]  cur_row,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, DECODE, WR_CHR, WR_ATR, SCR_RD, SCR_WR, CLR, CUR, DONE
  } state_t;

  localparam logic [6:0]  COL_MAX      = 7'(COLS - 1);
  localparam logic [4:0]  ROW_MAX      = 5'(ROWS - 1);
  localparam logic [11:0] IDX_CLR_LAST = 12'(ROWS * COLS * 2 - 1);
  localparam logic [11:0] IDX_SCR_LAST = 12'((ROWS - 1) * COLS * 2 - 1);
  localparam logic [11:0] IDX_BLANK    = 12'((ROWS - 1) * COLS * 2);

  state_t      state_q, state_d;
  logic [1:0]  ph_q, ph_d;
  logic [1:0]  step_q, step_d;
  logic [11:0] idx_q, idx_d;
  logic [7:0]  chr_q, chr_d;
  logic [7:0]  rd_q, rd_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic        ff_q, ff_d;

  logic        printable, known, bus_st, cyc_go, cyc_end, drive;
  logic [19:0] cell_addr;
  logic [7:0]  wdata;

  assign printable = (chr_q >= 8'h20) && (chr_q <= 8'h7E);
  assign known     = printable || (chr_q inside {8'h0D, 8'h0A, 8'h08, 8'h0C});
  assign bus_st    = state_q inside {WR_CHR, WR_ATR, SCR_RD, SCR_WR, CLR, CUR};
  // ph_q: 0=SETUP, 1=STROBE, 2=HOLD; a cycle may only begin (SETUP) while granted.
  assign cyc_go    = bus_st && ((ph_q != 2'd0) || bus_gnt);
  assign cyc_end   = bus_st && (ph_q == 2'd2);
  assign cell_addr = BASE + ((20'(row_q) * 20'(COLS) + 20'(col_q)) << 1);

  assign din_ready = (state_q == IDLE);
  assign busy      = ~din_ready;
  assign bus_req   = bus_st || ((state_q == DECODE) && known);
  assign cur_col   = col_q;
  assign cur_row   = row_q;
  assign d         = drive ? wdata : 8'hzz;

  always_comb begin
    a     = '0;
    wdata = '0;
    drive = 1'b0;
    memr  = 1'b0;
    memw  = 1'b0;
    iow   = 1'b0;
    if (cyc_go) begin
      case (state_q)
        WR_CHR: begin a = cell_addr;          wdata = chr_q; end
        WR_ATR: begin a = cell_addr + 20'd1;  wdata = ATTR;  end
        SCR_RD: a = BASE + 20'(2 * COLS) + 20'(idx_q);
        SCR_WR: begin a = BASE + 20'(idx_q);  wdata = rd_q;  end
        CLR:    begin a = BASE + 20'(idx_q);  wdata = idx_q[0] ? ATTR : 8'h20; end
        CUR: begin
          a = step_q[0] ? 20'h003D5 : 20'h003D4;
          case (step_q)
            2'd0:    wdata = 8'h0E;
            2'd1:    wdata = {3'b000, row_q};
            2'd2:    wdata = 8'h0F;
            default: wdata = {1'b0, col_q};
          endcase
        end
        default: ;
      endcase
      if (state_q == SCR_RD) begin
        memr = (ph_q != 2'd2);
      end else begin
        drive = 1'b1;
        if (ph_q == 2'd1) begin
          if (state_q == CUR) iow = 1'b1;
          else                memw = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    step_d  = step_q;
    idx_d   = idx_q;
    chr_d   = chr_q;
    rd_d    = rd_q;
    col_d   = col_q;
    row_d   = row_q;
    ff_d    = ff_q;
    if (cyc_go) ph_d = (ph_q == 2'd2) ? 2'd0 : ph_q + 2'd1;
    if ((state_q == SCR_RD) && cyc_go && (ph_q == 2'd1)) rd_d = d;
    case (state_q)
      IDLE: if (din_valid) begin
        chr_d   = din;
        state_d = DECODE;
      end
      DECODE: begin
        ph_d    = 2'd0;
        step_d  = 2'd0;
        idx_d   = '0;
        ff_d    = 1'b0;
        state_d = CUR;
        if (printable) begin
          state_d = WR_CHR;
        end else begin
          case (chr_q)
            8'h0D: col_d = '0;
            8'h0A: if (row_q != ROW_MAX) row_d = row_q + 5'd1; else state_d = SCR_RD;
            8'h08: if (col_q != 7'd0) col_d = col_q - 7'd1;
            8'h0C: begin state_d = CLR; ff_d = 1'b1; end
            default: state_d = IDLE;
          endcase
        end
      end
      WR_CHR: if (cyc_end) state_d = WR_ATR;
      WR_ATR: if (cyc_end) begin
        state_d = CUR;
        if (col_q != COL_MAX) begin
          col_d = col_q + 7'd1;
        end else begin
          col_d = '0;
          if (row_q != ROW_MAX) row_d = row_q + 5'd1;
          else                  state_d = SCR_RD;
        end
      end
      SCR_RD: if (cyc_end) state_d = SCR_WR;
      SCR_WR: if (cyc_end) begin
        if (idx_q == IDX_SCR_LAST) begin
          idx_d   = IDX_BLANK;
          state_d = CLR;
        end else begin
          idx_d   = idx_q + 12'd1;
          state_d = SCR_RD;
        end
      end
      // CLR serves both form feed (whole screen) and the blank bottom row after a scroll.
      CLR: if (cyc_end) begin
        if (idx_q == IDX_CLR_LAST) begin
          state_d = CUR;
          if (ff_q) begin
            col_d = '0;
            row_d = '0;
          end
        end else begin
          idx_d = idx_q + 12'd1;
        end
      end
      CUR: if (cyc_end) begin
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ph_q    <= '0;
      step_q  <= '0;
      idx_q   <= '0;
      chr_q   <= '0;
      rd_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
      ff_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      step_q  <= step_d;
      idx_q   <= idx_d;
      chr_q   <= chr_d;
      rd_q    <= rd_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ff_q    <= ff_d;
    end
  end

endmodule

// File: tb/tb_vdu_tty.sv
// Bench for vdu_tty: text memory and CRTC ports modelled here, DUT compared against
// a screen-level reference model.
module tb_vdu_tty;
  localparam logic [19:0] BASE = 20'hB8000;
  localparam logic [7:0]  ATTR = 8'h07;

  logic        clk, rst_n, din_valid, din_ready, bus_req, bus_gnt;
  logic        memr, memw, iow, busy;
  logic [7:0]  din;
  logic [19:0] a;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;
  wire  [7:0]  d;

  logic [7:0]  mem [0:4095];
  logic [7:0]  mdl [0:3999];
  int          mcol, mrow;
  logic [27:0] exp_q[$];
  logic [27:0] got_q[$];
  int          checks, failures, wr_cnt, oob_cnt;

  typedef struct {
    logic [7:0] din;
    int col;
    int row;
    int lat;
    int niow;
  } vec_t;
  vec_t tbl [10];

  vdu_tty dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .a(a), .d(d), .memr(memr), .memw(memw),
    .iow(iow), .cur_col(cur_col), .cur_row(cur_row), .busy(busy)
  );

  // clock / memory slave
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign d = memr ? mem[a[11:0]] : 8'hzz;

  always @(negedge clk) begin
    if (memw) begin
      if (a >= BASE && a < BASE + 20'd4000) mem[a[11:0]] = d;
      else oob_cnt++;
      wr_cnt++;
    end
    if (iow) got_q.push_back({a, d});
  end

  initial begin
    #1500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // reference model: screen rules applied to a byte array
  function automatic int model_byte(input logic [7:0] b);
    int memclk = 0;
    bit nl = 0;
    if (b >= 8'h20 && b <= 8'h7E) begin
      mdl[2 * (mrow * 80 + mcol)]     = b;
      mdl[2 * (mrow * 80 + mcol) + 1] = ATTR;
      memclk = 6;
      if (mcol == 79) begin mcol = 0; nl = 1; end
      else mcol++;
    end else if (b == 8'h0D) mcol = 0;
    else if (b == 8'h0A) nl = 1;
    else if (b == 8'h08) begin if (mcol > 0) mcol--; end
    else if (b == 8'h0C) begin
      for (int i = 0; i < 4000; i++) mdl[i] = (i % 2 == 1) ? ATTR : 8'h20;
      mcol = 0;
      mrow = 0;
      memclk = 12000;
    end else return 2;
    if (nl) begin
      if (mrow < 24) mrow++;
      else begin
        for (int i = 0; i < 3840; i++) mdl[i] = mdl[i + 160];
        for (int i = 3840; i < 4000; i++) mdl[i] = (i % 2 == 1) ? ATTR : 8'h20;
        memclk += 3840 * 6 + 160 * 3;
      end
    end
    exp_q.push_back({20'h003D4, 8'h0E});
    exp_q.push_back({20'h003D5, 8'(mrow)});
    exp_q.push_back({20'h003D4, 8'h0F});
    exp_q.push_back({20'h003D5, 8'(mcol)});
    return 15 + memclk;
  endfunction

  // driver tasks
  task automatic send_byte(input logic [7:0] b, output int lat);
    int n = 0;
    while (!din_ready && n < 40000) begin @(posedge clk); #1; n++; end
    if (!din_ready) chk("ready_before_send", din_ready, 1);
    @(negedge clk);
    din = b;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din = 8'h00;
    lat = 1;
    while (!din_ready && lat < 40000) begin @(posedge clk); #1; lat++; end
    if (!din_ready) chk("ready_timeout", din_ready, 1);
  endtask

  task automatic check_iow();
    int bad = 0;
    chk("iow_count", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) bad++;
    chk("iow_data", bad, 0);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic post_checks();
    int bad = 0;
    chk("cur_col", cur_col, mcol);
    chk("cur_row", cur_row, mrow);
    check_iow();
    for (int i = 0; i < 4000; i++) if (mem[i] !== mdl[i]) bad++;
    chk("mem", bad, 0);
  endtask

  task automatic step(input logic [7:0] b);
    int e, lat;
    e = model_byte(b);
    send_byte(b, lat);
    chk("latency", lat, e);
    post_checks();
  endtask

  task automatic gnt_drop();
    int n = 0, bad = 0, reqlow = 0;
    while (!memw && n < 200) begin @(negedge clk); n++; end
    chk("gnt_strobe_seen", memw, 1);
    bus_gnt = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k >= 2 && (memw || memr || iow || a != 20'd0)) bad++;
      if (!bus_req) reqlow++;
    end
    bus_gnt = 1'b1;
    chk("stall_quiet", bad, 0);
    chk("stall_bus_req", reqlow, 0);
  endtask

  initial begin
    int lat, e, bad, r;
    logic [7:0] b;
    logic [7:0] v1, v3;
    checks = 0; failures = 0; wr_cnt = 0; oob_cnt = 0;
    rst_n = 1'b0; bus_gnt = 1'b1; din_valid = 1'b0; din = 8'h00;
    mcol = 0; mrow = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 4000; i++) mdl[i] = mem[i];

    repeat (3) @(posedge clk);
    #1;
    chk("rst_din_ready", din_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_a", a, 0);
    chk("rst_strobes", {memr, memw, iow}, 0);
    chk("rst_d_z", d === 8'hzz, 1);
    chk("rst_col", cur_col, 0);
    chk("rst_row", cur_row, 0);
    @(negedge clk);
    rst_n = 1'b1;

    tbl[0] = '{8'h41, 1, 0, 21, 4};
    tbl[1] = '{8'h0D, 0, 0, 15, 4};
    tbl[2] = '{8'h08, 0, 0, 15, 4};
    tbl[3] = '{8'h07, 0, 0, 2, 0};
    tbl[4] = '{8'h0A, 0, 1, 15, 4};
    tbl[5] = '{8'h42, 1, 1, 21, 4};
    tbl[6] = '{8'h43, 2, 1, 21, 4};
    tbl[7] = '{8'h08, 1, 1, 15, 4};
    tbl[8] = '{8'h0D, 0, 1, 15, 4};
    tbl[9] = '{8'hFF, 0, 1, 2, 0};
    for (int i = 0; i < 10; i++) begin
      e = model_byte(tbl[i].din);
      send_byte(tbl[i].din, lat);
      chk("tbl_latency", lat, tbl[i].lat);
      chk("tbl_niow", got_q.size(), tbl[i].niow);
      chk("tbl_col", cur_col, tbl[i].col);
      chk("tbl_row", cur_row, tbl[i].row);
      post_checks();
    end
    chk("first_char", mem[0], 8'h41);
    chk("first_attr", mem[1], ATTR);

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      b = 8'($urandom_range(32, 126));
      else if (r < 78) b = 8'h0D;
      else if (r < 85) b = 8'h0A;
      else if (r < 92) b = 8'h08;
      else             b = 8'($urandom_range(0, 255));
      if (b == 8'h0C) b = 8'h00;
      if (mrow == 24 && (b == 8'h0A || (mcol == 79 && b >= 8'h20 && b <= 8'h7E))) b = 8'h0D;
      step(b);
    end

    // form feed
    wr_cnt = 0;
    e = model_byte(8'h0C);
    send_byte(8'h0C, lat);
    chk("ff_latency", lat, e);
    chk("ff_writes", wr_cnt, 4000);
    bad = 0;
    for (int i = 0; i < 4000; i++) if (mem[i] !== ((i % 2 == 1) ? ATTR : 8'h20)) bad++;
    chk("ff_blank", bad, 0);
    v1 = (got_q.size() == 4) ? got_q[1][7:0] : 8'hEE;
    v3 = (got_q.size() == 4) ? got_q[3][7:0] : 8'hEE;
    chk("ff_iow_row", v1, 0);
    chk("ff_iow_col", v3, 0);
    post_checks();

    // wrap at last column
    for (int i = 0; i < 79; i++) step(8'h78);
    e = model_byte(8'h79);
    send_byte(8'h79, lat);
    chk("wrap_latency", lat, e);
    chk("wrap_char", mem[12'h09E], 8'h79);
    chk("wrap_attr", mem[12'h09F], ATTR);
    v1 = (got_q.size() == 4) ? got_q[1][7:0] : 8'hEE;
    v3 = (got_q.size() == 4) ? got_q[3][7:0] : 8'hEE;
    chk("wrap_iow_row", v1, 1);
    chk("wrap_iow_col", v3, 0);
    post_checks();

    // grant withdrawn mid character write
    e = model_byte(8'h5A);
    fork
      send_byte(8'h5A, lat);
      gnt_drop();
    join
    post_checks();

    // scroll at bottom row
    mem[160] = 8'h51; mem[161] = 8'h1F;
    mdl[160] = 8'h51; mdl[161] = 8'h1F;
    while (mrow < 24) step(8'h0A);
    step(8'h0A);
    chk("scroll_char", mem[0], 8'h51);
    chk("scroll_attr", mem[1], 8'h1F);
    bad = 0;
    for (int i = 3840; i < 4000; i++) if (mem[i] !== ((i % 2 == 1) ? ATTR : 8'h20)) bad++;
    chk("scroll_blank_row", bad, 0);
    chk("scroll_row", cur_row, 24);

    // reset during a scroll
    @(negedge clk);
    din = 8'h0A;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    repeat (300) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_strobes", {memr, memw, iow}, 0);
    chk("abort_d_z", d === 8'hzz, 1);
    chk("abort_a", a, 0);
    chk("abort_bus_req", bus_req, 0);
    chk("abort_col", cur_col, 0);
    chk("abort_row", cur_row, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_ready", din_ready, 1);
    chk("abort_busy", busy, 0);
    for (int i = 0; i < 4000; i++) mdl[i] = mem[i];
    mcol = 0; mrow = 0;
    got_q.delete(); exp_q.delete();
    step(8'h41);
    chk("post_abort_char", mem[0], 8'h41);

    chk("oob_writes", oob_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
